// File: rtl/cmpacc_pkg.sv
// Shared constants and types for the cmpacc engine and its scheduler.
package cmpacc_pkg;

    localparam int unsigned BITMAP_W = 1536;
    localparam int unsigned ROWS     = 64;
    localparam int unsigned COLS     = 24;
    localparam int unsigned RESULT_W = 13;

    // Result field positions: [12:11] flags, [10:5] row, [4:0] col
    localparam int unsigned RES_COL_LSB   = 0;
    localparam int unsigned RES_COL_MSB   = 4;
    localparam int unsigned RES_ROW_LSB   = 5;
    localparam int unsigned RES_ROW_MSB   = 10;
    localparam int unsigned RES_FLAGS_LSB = 11;
    localparam int unsigned RES_FLAGS_MSB = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } sched_state_t;

endpackage

// File: rtl/cmpacc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % int'(N));
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/cmpacc_sched.sv
// Shares one cmpacc engine among NREQ requesters: round-robin grant, load, wait with timeout,
// then a one-cycle response to the owner.
module cmpacc_sched
    import cmpacc_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 500
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*BITMAP_W-1:0]     req_bitmap,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [RESULT_W-1:0]          rsp_result,
    output logic                         rsp_timeout,
    output logic [BITMAP_W-1:0]          acc_bitmap,
    output logic                         acc_wren,
    input  logic [RESULT_W-1:0]          acc_result,
    input  logic                         acc_done,
    output logic                         busy,
    output logic [$clog2(NREQ)-1:0]      sel_id
);

    localparam int unsigned IDX_W  = $clog2(NREQ);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT);

    sched_state_t          r_state,       w_state_nxt;
    logic [IDX_W-1:0]      r_rr_ptr,      w_rr_ptr_nxt;
    logic [IDX_W-1:0]      r_sel_id,      w_sel_id_nxt;
    logic [WCNT_W-1:0]     r_wait_cnt,    w_wait_cnt_nxt;
    logic [BITMAP_W-1:0]   r_acc_bitmap,  w_acc_bitmap_nxt;
    logic                  r_acc_wren,    w_acc_wren_nxt;
    logic [NREQ-1:0]       r_rsp_valid,   w_rsp_valid_nxt;
    logic [RESULT_W-1:0]   r_rsp_result,  w_rsp_result_nxt;
    logic                  r_rsp_timeout, w_rsp_timeout_nxt;
    logic                  r_busy,        w_busy_nxt;

    logic [NREQ-1:0]       w_gnt;
    logic [IDX_W-1:0]      w_gnt_idx;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Only one job in flight: accept solely while idle
    assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;

    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_sel_id_nxt      = r_sel_id;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_acc_bitmap_nxt  = r_acc_bitmap;
        w_acc_wren_nxt    = 1'b0;
        w_rsp_valid_nxt   = '0;
        w_rsp_result_nxt  = r_rsp_result;
        w_rsp_timeout_nxt = r_rsp_timeout;
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_acc_bitmap_nxt = req_bitmap[int'(w_gnt_idx)*BITMAP_W +: BITMAP_W];
                    w_sel_id_nxt     = w_gnt_idx;
                    w_rr_ptr_nxt     = IDX_W'((int'(w_gnt_idx) + 1) % int'(NREQ));
                    w_acc_wren_nxt   = 1'b1;
                    w_state_nxt      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt != '1) begin
                    w_wait_cnt_nxt = r_wait_cnt + WCNT_W'(1);
                end
                // A done seen in the first WAIT cycle may be left over from the previous job
                if (acc_done && (r_wait_cnt != '0)) begin
                    w_rsp_result_nxt  = acc_result;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = NREQ'(1) << r_sel_id;
                    w_state_nxt       = ST_RESP;
                end else if (r_wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                    w_rsp_result_nxt  = '0;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_valid_nxt   = NREQ'(1) << r_sel_id;
                    w_state_nxt       = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_sel_id      <= '0;
            r_wait_cnt    <= '0;
            r_acc_bitmap  <= '0;
            r_acc_wren    <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_sel_id      <= w_sel_id_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_acc_bitmap  <= w_acc_bitmap_nxt;
            r_acc_wren    <= w_acc_wren_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_result  <= w_rsp_result_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign acc_bitmap  = r_acc_bitmap;
    assign acc_wren    = r_acc_wren;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;
    assign sel_id      = r_sel_id;

endmodule

// File: tb/tb_cmpacc_sched.sv
// Directed bench for cmpacc_sched; the bench itself plays the cmpacc engine.
module tb_cmpacc_sched;
    import cmpacc_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 500;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ*BITMAP_W-1:0] req_bitmap;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          rsp_valid;
    logic [RESULT_W-1:0]      rsp_result;
    logic                     rsp_timeout;
    logic [BITMAP_W-1:0]      acc_bitmap;
    logic                     acc_wren;
    logic [RESULT_W-1:0]      acc_result = '0;
    logic                     acc_done = 1'b0;
    logic                     busy;
    logic [1:0]               sel_id;

    logic [BITMAP_W-1:0]      bm_tb [NREQ];

    int n_checks = 0;
    int n_fail   = 0;
    int wren_cnt = 0;

    assign req_bitmap = {bm_tb[3], bm_tb[2], bm_tb[1], bm_tb[0]};

    always #5 clk = ~clk;

    always @(negedge clk) if (acc_wren) wren_cnt++;

    cmpacc_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_bitmap  (req_bitmap),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_timeout (rsp_timeout),
        .acc_bitmap  (acc_bitmap),
        .acc_wren    (acc_wren),
        .acc_result  (acc_result),
        .acc_done    (acc_done),
        .busy        (busy),
        .sel_id      (sel_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the LOAD cycle, answer done on the earliest accepted WAIT cycle; ends in RESP
    task automatic drive_to_resp(input logic [RESULT_W-1:0] res);
        acc_result = res;
        tick();
        tick();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        acc_done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        n_checks++; if (rsp_result !== 13'h0) begin n_fail++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
        n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_timeout: got %b expected 0", rsp_timeout); end
        n_checks++; if (acc_bitmap !== '0) begin n_fail++; $display("FAIL reset_acc_bitmap: got nonzero expected 0"); end
        n_checks++; if (acc_wren !== 1'b0) begin n_fail++; $display("FAIL reset_acc_wren: got %b expected 0", acc_wren); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (sel_id !== 2'd0) begin n_fail++; $display("FAIL reset_sel_id: got %0d expected 0", sel_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.r_rr_ptr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        logic [RESULT_W-1:0] exp_res;
        int wren_start;
        exp_res = '0;
        exp_res[RES_COL_MSB:RES_COL_LSB]     = 5'd2;
        exp_res[RES_ROW_MSB:RES_ROW_LSB]     = 6'd2;
        exp_res[RES_FLAGS_MSB:RES_FLAGS_LSB] = 2'd0;
        wren_start = wren_cnt;
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
        tick();
        // LOAD: request still asserted but must not be accepted again
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_load: got %b expected 0000", req_ready); end
        n_checks++; if (acc_wren !== 1'b1) begin n_fail++; $display("FAIL single_wren: got %b expected 1", acc_wren); end
        n_checks++; if (sel_id !== 2'd1) begin n_fail++; $display("FAIL single_sel_id: got %0d expected 1", sel_id); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
        n_checks++; if (acc_bitmap !== bm_tb[1]) begin n_fail++; $display("FAIL single_bitmap: got %h expected %h", acc_bitmap[BITMAP_W-1 -: 96], bm_tb[1][BITMAP_W-1 -: 96]); end
        req_valid  = 4'b0000;
        acc_result = exp_res;
        tick();
        tick();
        tick();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0010", rsp_valid); end
        n_checks++; if (rsp_result !== exp_res) begin n_fail++; $display("FAIL single_rsp_result: got %h expected %h", rsp_result, exp_res); end
        n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL single_rsp_timeout: got %b expected 0", rsp_timeout); end
        n_checks++; if (acc_bitmap !== bm_tb[1]) begin n_fail++; $display("FAIL single_bitmap_held: bitmap changed before response"); end
        tick();
        n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_pulse: got %b expected 0000", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        n_checks++; if (wren_cnt - wren_start !== 1) begin n_fail++; $display("FAIL single_wren_count: got %0d expected 1", wren_cnt - wren_start); end
    endtask

    task automatic test_contention();
        do_reset();
        req_valid = 4'b0101;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL cont_ready0: got %b expected 0001", req_ready); end
        tick();
        n_checks++; if (sel_id !== 2'd0) begin n_fail++; $display("FAIL cont_sel0: got %0d expected 0", sel_id); end
        req_valid = 4'b0100;
        drive_to_resp(13'h0123);
        n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL cont_rsp0: got %b expected 0001", rsp_valid); end
        tick();
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL cont_ready2: got %b expected 0100", req_ready); end
        tick();
        n_checks++; if (sel_id !== 2'd2) begin n_fail++; $display("FAIL cont_sel2: got %0d expected 2", sel_id); end
        n_checks++; if (dut.r_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL cont_rr_ptr: got %0d expected 3", dut.r_rr_ptr); end
        req_valid = 4'b0000;
        drive_to_resp(13'h0456);
        n_checks++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL cont_rsp2: got %b expected 0100", rsp_valid); end
        n_checks++; if (rsp_result !== 13'h0456) begin n_fail++; $display("FAIL cont_result2: got %h expected 0456", rsp_result); end
        tick();
    endtask

    // All requesters held: grants must rotate 0,1,2,3,0,1,2,3 with no idle gap beyond one cycle
    task automatic test_fairness();
        logic [1:0]          exp_idx;
        logic [3:0]          exp_oh;
        logic [RESULT_W-1:0] res;
        do_reset();
        req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            exp_idx = 2'(j % 4);
            exp_oh  = 4'b0001 << exp_idx;
            res     = 13'(j * 37 + 5);
            #1;
            n_checks++; if (req_ready !== exp_oh) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b expected %b", j, req_ready, exp_oh); end
            tick();
            n_checks++; if (sel_id !== exp_idx) begin n_fail++; $display("FAIL fair_sel[%0d]: got %0d expected %0d", j, sel_id, exp_idx); end
            n_checks++; if (acc_bitmap !== bm_tb[exp_idx]) begin n_fail++; $display("FAIL fair_bitmap[%0d]: wrong slice loaded", j); end
            drive_to_resp(res);
            n_checks++; if (rsp_valid !== exp_oh || rsp_result !== res) begin n_fail++; $display("FAIL fair_rsp[%0d]: got %b/%h expected %b/%h", j, rsp_valid, rsp_result, exp_oh, res); end
            tick();
        end
        req_valid = 4'b0000;
        tick();
    endtask

    // Engine never finishes: 500 WAIT cycles, then a zeroed timeout response
    task automatic test_timeout();
        int n;
        req_valid  = 4'b1000;
        acc_result = 13'h1fff;
        acc_done   = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL to_ready: got %b expected 1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid === 4'b0000 && n < 600);
        n_checks++; if (n !== TIMEOUT + 1) begin n_fail++; $display("FAIL to_latency: got %0d cycles after LOAD expected %0d", n, TIMEOUT + 1); end
        n_checks++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL to_rsp_valid: got %b expected 1000", rsp_valid); end
        n_checks++; if (rsp_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", rsp_timeout); end
        n_checks++; if (rsp_result !== 13'h0) begin n_fail++; $display("FAIL to_result: got %h expected 0", rsp_result); end
        tick();
    endtask

    task automatic test_stale_done();
        acc_done   = 1'b1;
        acc_result = 13'h0abc;
        req_valid  = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        // Response here would mean done was taken in the first WAIT cycle
        n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL stale_early: got %b expected 0000", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL stale_rsp: got %b expected 0001", rsp_valid); end
        n_checks++; if (rsp_result !== 13'h0abc || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL stale_result: got %h/%b expected 0abc/0", rsp_result, rsp_timeout); end
        acc_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_job();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || acc_wren !== 1'b0 || sel_id !== 2'd0) begin n_fail++; $display("FAIL rmid_ctrl: got busy=%b wren=%b sel=%0d expected 0/0/0", busy, acc_wren, sel_id); end
        n_checks++; if (acc_bitmap !== '0) begin n_fail++; $display("FAIL rmid_bitmap: got nonzero expected 0"); end
        n_checks++; if (rsp_valid !== 4'b0000 || rsp_result !== 13'h0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp: got %b/%h/%b expected 0", rsp_valid, rsp_result, rsp_timeout); end
        acc_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_no_rsp[%0d]: got %b expected 0000", c, rsp_valid); end
        end
        acc_done = 1'b0;
        rst_n    = 1'b1;
        tick();
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_repost_ready: got %b expected 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_checks++; if (acc_bitmap !== bm_tb[1]) begin n_fail++; $display("FAIL rmid_repost_bitmap: wrong slice loaded"); end
        drive_to_resp(13'h1555);
        n_checks++; if (rsp_valid !== 4'b0010 || rsp_result !== 13'h1555) begin n_fail++; $display("FAIL rmid_repost_rsp: got %b/%h expected 0010/1555", rsp_valid, rsp_result); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < int'(NREQ); i++) bm_tb[i] = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (r <= 3)                bm_tb[1][BITMAP_W-1-r*COLS -: COLS] = 24'h3fffff;
            else if (r >= 36 && r <= 61) bm_tb[1][BITMAP_W-1-r*COLS -: COLS] = 24'h3f0000;
        end
        bm_tb[0] = {ROWS{24'h0a0a0a}};
        bm_tb[2] = {ROWS{24'h0c0c0c}};
        bm_tb[3] = {ROWS{24'h0d0d0d}};

        test_reset();
        test_single_job();
        test_contention();
        test_fairness();
        test_timeout();
        test_stale_done();
        test_reset_mid_job();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
